// File: rtl/bw_io_ddr_rptr_pipe.sv
// DDR pad-ring repeater pipe: NCH x WIDTH channels retimed through DEPTH stages with valid,
// hold/flush, channel gating, occupancy and bypass. Define BW_IO_DDR_RPTR_PARITY_EN for parity checking.
module bw_io_ddr_rptr_pipe #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int OCCW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byp,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [NCH-1:0]        chan_en,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic                  in_vld,
    output logic [NCH*WIDTH-1:0]  out_data,
    output logic                  out_vld,
    output logic [OCCW-1:0]       occ,
    output logic                  par_err
);
    localparam int DW = NCH * WIDTH;

    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [DEPTH-1:0]         r_vld;
    logic [OCCW-1:0]          r_occ;
    logic [DW-1:0]            w_gated;

    // Occupancy moves by at most one per edge and is clamped to 0..DEPTH.
    function automatic logic [OCCW-1:0] occ_step(input logic [OCCW-1:0] cur,
                                                 input logic enter, input logic leave);
        logic [OCCW-1:0] nxt;
        nxt = cur;
        if (enter && !leave && (cur != OCCW'(DEPTH)))
            nxt = cur + OCCW'(1);
        else if (leave && !enter && (cur != '0))
            nxt = cur - OCCW'(1);
        return nxt;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_gate
        assign w_gated[c*WIDTH +: WIDTH] = chan_en[c] ? in_data[c*WIDTH +: WIDTH] : '0;
    end

    // Bypass keeps the pipe flushed so leaving bypass always starts from empty.
    always_ff @(posedge clk) begin
        if (rst || flush || byp) begin
            r_data <= '0;
            r_vld  <= '0;
            r_occ  <= '0;
        end else if (!hold) begin
            r_data[0] <= w_gated;
            r_vld[0]  <= in_vld;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
            r_occ <= occ_step(r_occ, in_vld, r_vld[DEPTH-1]);
        end
    end

    assign out_data = byp ? w_gated : r_data[DEPTH-1];
    assign out_vld  = byp ? in_vld  : r_vld[DEPTH-1];
    assign occ      = byp ? '0      : r_occ;

`ifdef BW_IO_DDR_RPTR_PARITY_EN
    logic [DEPTH-1:0][NCH-1:0] r_par;
    logic                      r_par_err;

    function automatic logic [NCH-1:0] par_of(input logic [DW-1:0] d);
        logic [NCH-1:0] p;
        for (int c = 0; c < NCH; c++)
            p[c] = ^d[c*WIDTH +: WIDTH];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush || byp) begin
            r_par <= '0;
        end else if (!hold) begin
            r_par[0] <= par_of(w_gated);
            for (int k = 1; k < DEPTH; k++)
                r_par[k] <= r_par[k-1];
        end
    end

    // Sticky: only reset clears it; bypass freezes it.
    always_ff @(posedge clk) begin
        if (rst)
            r_par_err <= 1'b0;
        else if (!byp && r_vld[DEPTH-1] && (par_of(r_data[DEPTH-1]) != r_par[DEPTH-1]))
            r_par_err <= 1'b1;
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_bw_io_ddr_rptr_pipe.sv
// Self-checking bench for bw_io_ddr_rptr_pipe: directed steps plus random traffic against a queue model.
module tb_bw_io_ddr_rptr_pipe;
    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int OCCW  = 4;
    localparam int DW    = NCH * WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            byp = 1'b0;
    logic            hold = 1'b0;
    logic            flush = 1'b0;
    logic [NCH-1:0]  chan_en = '1;
    logic [DW-1:0]   in_data = '0;
    logic            in_vld = 1'b0;
    logic [DW-1:0]   out_data;
    logic            out_vld;
    logic [OCCW-1:0] occ;
    logic            par_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    bit            vq[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] tmp;

    always #5 clk = ~clk;

    bw_io_ddr_rptr_pipe #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .OCCW(OCCW)) dut (
        .clk(clk), .rst(rst), .byp(byp), .hold(hold), .flush(flush),
        .chan_en(chan_en), .in_data(in_data), .in_vld(in_vld),
        .out_data(out_data), .out_vld(out_vld), .occ(occ), .par_err(par_err)
    );

    function automatic logic [DW-1:0] gate(input logic [DW-1:0] d, input logic [NCH-1:0] en);
        logic [DW-1:0] m;
        m = '0;
        for (int c = 0; c < NCH; c++)
            if (en[c]) m = m | (DW'({WIDTH{1'b1}}) << (c * WIDTH));
        return d & m;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cyc();
        int cnt;
        @(posedge clk);
        if (rst || flush || byp) begin
            mq.delete();
            vq.delete();
            repeat (DEPTH) begin
                mq.push_back('0);
                vq.push_back(1'b0);
            end
        end else if (!hold) begin
            mq.push_front(gate(in_data, chan_en));
            vq.push_front(in_vld);
            void'(mq.pop_back());
            void'(vq.pop_back());
        end
        #1;
        cnt = 0;
        foreach (vq[i]) cnt += int'(vq[i]);
        if (byp) begin
            chk("m_data", out_data, gate(in_data, chan_en));
            chk("m_vld", DW'(out_vld), DW'(in_vld));
            chk("m_occ", DW'(occ), '0);
        end else begin
            chk("m_data", out_data, mq[DEPTH-1]);
            chk("m_vld", DW'(out_vld), DW'(vq[DEPTH-1]));
            chk("m_occ", DW'(occ), DW'(cnt));
        end
        chk("m_par", DW'(par_err), '0);
    endtask

    initial begin
        repeat (DEPTH) begin
            mq.push_back('0);
            vq.push_back(1'b0);
        end

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_occ", DW'(occ), 0);
        chk("rst_vld", DW'(out_vld), 0);
        chk("rst_data", out_data, 0);
        chk("rst_par", DW'(par_err), 0);
        rst = 1'b0;

        // Single word latency
        in_vld = 1'b1; in_data = 32'hA5A5_5A5A; chan_en = 4'hF;
        cyc();
        chk("t1_occ_e0", DW'(occ), 1);
        in_vld = 1'b0; in_data = '0;
        cyc();
        chk("t1_occ_e1", DW'(occ), 1);
        chk("t1_vld_e1", DW'(out_vld), 0);
        cyc();
        chk("t1_vld_e2", DW'(out_vld), 1);
        chk("t1_data_e2", out_data, 32'hA5A5_5A5A);
        chk("t1_occ_e2", DW'(occ), 1);
        cyc();
        chk("t1_occ_e3", DW'(occ), 0);
        chk("t1_vld_e3", DW'(out_vld), 0);

        // Back-to-back with a two-cycle hold
        got.delete();
        in_vld = 1'b1; in_data = 32'd1; cyc(); if (out_vld) got.push_back(out_data);
        in_data = 32'd2; cyc(); if (out_vld) got.push_back(out_data);
        hold = 1'b1; in_data = 32'd99;
        cyc(); if (out_vld) got.push_back(out_data);
        chk("t2_occ_h0", DW'(occ), 2);
        cyc(); if (out_vld) got.push_back(out_data);
        chk("t2_occ_h1", DW'(occ), 2);
        hold = 1'b0;
        in_data = 32'd3; cyc(); if (out_vld) got.push_back(out_data);
        in_data = 32'd4; cyc(); if (out_vld) got.push_back(out_data);
        in_vld = 1'b0; in_data = '0;
        repeat (4) begin
            cyc();
            if (out_vld) got.push_back(out_data);
        end
        chk("t2_count", DW'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("t2_order", got[i], DW'(i + 1));

        // Full pipe, then flush together with hold
        in_vld = 1'b1;
        repeat (3) begin
            in_data = $urandom;
            cyc();
        end
        chk("t3_full", DW'(occ), 3);
        flush = 1'b1; hold = 1'b1;
        cyc();
        chk("t3_occ", DW'(occ), 0);
        chk("t3_vld", DW'(out_vld), 0);
        chk("t3_data", out_data, 0);
        flush = 1'b0; hold = 1'b0; in_vld = 1'b0;
        cyc();

        // Channel gating, registered and bypassed
        chan_en = 4'b1010; in_data = 32'hFFFF_FFFF; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        cyc();
        cyc();
        chk("t4_data", out_data, 32'hFF00_FF00);
        chk("t4_vld", DW'(out_vld), 1);
        byp = 1'b1; in_vld = 1'b1;
        #1;
        chk("t4_byp_data", out_data, 32'hFF00_FF00);
        chk("t4_byp_vld", DW'(out_vld), 1);
        chk("t4_byp_occ", DW'(occ), 0);
        cyc();
        byp = 1'b0; in_vld = 1'b0; chan_en = 4'hF;
        cyc();

        // Reset mid-stream overrides hold
        in_vld = 1'b1; in_data = 32'h11; cyc();
        in_data = 32'h22; cyc();
        chk("t5_occ2", DW'(occ), 2);
        rst = 1'b1; hold = 1'b1;
        cyc();
        chk("t5_occ", DW'(occ), 0);
        chk("t5_vld", DW'(out_vld), 0);
        chk("t5_data", out_data, 0);
        rst = 1'b0; hold = 1'b0; in_vld = 1'b1; in_data = 32'h77;
        cyc();
        in_vld = 1'b0; in_data = '0;
        cyc();
        chk("t5_early", DW'(out_vld), 0);
        cyc();
        chk("t5_vld_lat", DW'(out_vld), 1);
        chk("t5_data_lat", out_data, 32'h77);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            hold    = ($urandom_range(0, 5) == 0);
            byp     = rst ? 1'b0 : ($urandom_range(0, 24) == 0);
            in_vld  = 1'($urandom_range(0, 1));
            in_data = $urandom;
            chan_en = 4'($urandom);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; hold = 1'b0; byp = 1'b0; in_vld = 1'b0; chan_en = 4'hF;
        cyc();

`ifdef BW_IO_DDR_RPTR_PARITY_EN
        // Corrupt a word in stage 2 and expect the sticky error at the output
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; in_vld = 1'b1; in_data = 32'h1234_5678;
        @(posedge clk); #1;
        in_vld = 1'b0; in_data = '0;
        @(posedge clk); #1;
        tmp = dut.r_data[1];
        force dut.r_data[1] = tmp ^ 32'h1;
        @(posedge clk); #1;
        release dut.r_data[1];
        chk("p_before", DW'(par_err), 0);
        @(posedge clk); #1;
        chk("p_set", DW'(par_err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("p_sticky", DW'(par_err), 1);
        rst = 1'b1; @(posedge clk); #1;
        chk("p_clear", DW'(par_err), 0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
